// File: rtl/pipelined_skip_adder.sv
// Pipelined signed carry-skip adder/subtractor with valid/ready flow control.
// BLOCKS_PER_STAGE skip blocks are resolved per register stage; per-block skip usage is reported.
module pipelined_skip_adder #(
    parameter int WIDTH            = 16,
    parameter int BLOCK            = 4,
    parameter int BLOCKS_PER_STAGE = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [WIDTH-1:0]         a_i,
    input  logic [WIDTH-1:0]         b_i,
    input  logic                     cin_i,
    input  logic                     sub_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [WIDTH-1:0]         sum_o,
    output logic                     cout_o,
    output logic                     ovf_o,
    output logic [WIDTH/BLOCK-1:0]   skip_o
);

    localparam int NB  = WIDTH / BLOCK;
    localparam int BPS = BLOCKS_PER_STAGE;
    localparam int LAT = NB / BPS;
    localparam int MSB = WIDTH - 1;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // The whole pipe freezes only when the last stage holds a result nobody takes;
    // otherwise every stage (bubbles included) moves forward one slot.
    logic stall;

    logic [WIDTH-1:0] a_q     [LAT];
    logic [WIDTH-1:0] be_q    [LAT];
    logic [WIDTH-1:0] sum_q   [LAT];
    logic             carry_q [LAT];
    logic             valid_q [LAT];
    logic [NB-1:0]    skip_q  [LAT];
    logic             ovf_q;

    logic [WIDTH-1:0] src_a     [LAT];
    logic [WIDTH-1:0] src_be    [LAT];
    logic [WIDTH-1:0] src_sum   [LAT];
    logic             src_carry [LAT];
    logic             src_valid [LAT];
    logic [NB-1:0]    src_skip  [LAT];

    logic [WIDTH-1:0] sum_d   [LAT];
    logic             carry_d [LAT];
    logic [NB-1:0]    skip_d  [LAT];
    logic             ovf_d;

    logic chain_c;
    logic blk_c;
    logic blk_p;
    logic bit_x;

    assign stall      = valid_q[LAT-1] & ~out_ready_i;
    assign in_ready_o = ~stall;

    // Stage 0 takes the raw operands; later stages take the previous stage register.
    always_comb begin
        src_a[0]     = a_i;
        src_be[0]    = sub_i ? ~b_i : b_i;
        src_sum[0]   = '0;
        src_carry[0] = sub_i | cin_i;
        src_valid[0] = in_valid_i;
        src_skip[0]  = '0;
        for (int s = 1; s < LAT; s++) begin
            src_a[s]     = a_q[s-1];
            src_be[s]    = be_q[s-1];
            src_sum[s]   = sum_q[s-1];
            src_carry[s] = carry_q[s-1];
            src_valid[s] = valid_q[s-1];
            src_skip[s]  = skip_q[s-1];
        end
    end

    // Each block ripples its sum bits from the true carry-in, while the carry
    // handed to the next block bypasses the ripple when the block fully propagates.
    always_comb begin
        chain_c = 1'b0;
        blk_c   = 1'b0;
        blk_p   = 1'b0;
        bit_x   = 1'b0;
        for (int s = 0; s < LAT; s++) begin
            sum_d[s]  = src_sum[s];
            skip_d[s] = src_skip[s];
            chain_c   = src_carry[s];
            for (int j = 0; j < BPS; j++) begin
                blk_c = chain_c;
                blk_p = 1'b1;
                for (int i = 0; i < BLOCK; i++) begin
                    bit_x = src_a[s][(s*BPS+j)*BLOCK+i] ^ src_be[s][(s*BPS+j)*BLOCK+i];
                    sum_d[s][(s*BPS+j)*BLOCK+i] = bit_x ^ blk_c;
                    blk_c = (src_a[s][(s*BPS+j)*BLOCK+i] & src_be[s][(s*BPS+j)*BLOCK+i])
                          | (bit_x & blk_c);
                    blk_p = blk_p & bit_x;
                end
                skip_d[s][s*BPS+j] = blk_p;
                chain_c = blk_p ? chain_c : blk_c;
            end
            carry_d[s] = chain_c;
        end
        ovf_d = (src_a[LAT-1][MSB] == src_be[LAT-1][MSB])
             && (sum_d[LAT-1][MSB] != src_a[LAT-1][MSB]);
    end

    // Payload is only loaded alongside a valid bit so bubbles leave old data untouched.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < LAT; s++) begin
                valid_q[s] <= 1'b0;
                a_q[s]     <= '0;
                be_q[s]    <= '0;
                sum_q[s]   <= '0;
                carry_q[s] <= 1'b0;
                skip_q[s]  <= '0;
            end
            ovf_q <= 1'b0;
        end else if (!stall) begin
            for (int s = 0; s < LAT; s++) begin
                valid_q[s] <= src_valid[s];
                if (src_valid[s]) begin
                    a_q[s]     <= src_a[s];
                    be_q[s]    <= src_be[s];
                    sum_q[s]   <= sum_d[s];
                    carry_q[s] <= carry_d[s];
                    skip_q[s]  <= skip_d[s];
                end
            end
            if (src_valid[LAT-1]) begin
                ovf_q <= ovf_d;
            end
        end
    end

    assign out_valid_o = valid_q[LAT-1];
    assign sum_o       = sum_q[LAT-1];
    assign cout_o      = carry_q[LAT-1];
    assign ovf_o       = ovf_q;
    assign skip_o      = skip_q[LAT-1];

endmodule

// File: tb/tb_pipelined_skip_adder.sv
// Scoreboard bench for pipelined_skip_adder: a driver pushes model results, a monitor pops on output transfers.
`timescale 1ns/1ps
module tb_pipelined_skip_adder;

    localparam int W  = 16;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          cin = 1'b0;
    logic          sub = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic [NB-1:0] skip;

    int n_checks = 0;
    int n_bad    = 0;
    int ready_mode = 0;   // 0: always ready, 1: never ready, 2: random
    logic [21:0] exp_q[$];
    logic [21:0] mon_exp;

    always #5 clk = ~clk;

    pipelined_skip_adder dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .cin_i       (cin),
        .sub_i       (sub),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .sum_o       (sum),
        .cout_o      (cout),
        .ovf_o       (ovf),
        .skip_o      (skip)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name);
        n_checks++;
        n_bad++;
        $display("FAIL %s: event did not happen within its bound at %0t", name, $time);
    endtask

    // Reference: plain integer arithmetic, signed range test for overflow.
    function automatic logic [21:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                          input logic cv, input logic sv);
        logic [W-1:0]  be;
        int            full;
        int            true_sum;
        logic          ovf_m;
        logic [NB-1:0] sk;
        be       = sv ? ~bv : bv;
        full     = int'(av) + int'(be) + (sv ? 1 : int'(cv));
        true_sum = sv ? (int'($signed(av)) - int'($signed(bv)))
                      : (int'($signed(av)) + int'($signed(bv)) + int'(cv));
        ovf_m    = (true_sum > 32767) || (true_sum < -32768);
        for (int k = 0; k < NB; k++) begin
            sk[k] = ((((av ^ be) >> (4 * k)) & 16'hF) == 16'hF);
        end
        return {full[15:0], full[16], ovf_m, sk};
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic send_exp(input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic cv, input logic sv, input logic [21:0] ev);
        int waited;
        waited = 0;
        @(negedge clk);
        a = av;
        b = bv;
        cin = cv;
        sub = sv;
        in_valid = 1'b1;
        #2;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            #2;
            waited++;
        end
        if (!in_ready) begin
            note_fail("accept_timeout");
        end else begin
            exp_q.push_back(ev);
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic sv);
        send_exp(av, bv, cv, sv, model(av, bv, cv, sv));
    endtask

    // Pipeline must be empty: result is not visible after the accept edge, but is after the next one.
    task automatic send_lat(input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic cv, input logic sv, input logic [21:0] ev);
        send_exp(av, bv, cv, sv, ev);
        check("latency_early", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("latency_on_time", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        check(name, exp_q.size(), 32'd0);
    endtask

    task automatic stall_check();
        int t;
        logic [22:0] snap;
        t = 0;
        while (!out_valid && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!out_valid) begin
            note_fail("stall_first_valid");
        end else begin
            ready_mode = 1;
            @(negedge clk);
            #2;
            snap = {out_valid, sum, cout, ovf, skip};
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            for (int i = 1; i < 3; i++) begin
                @(negedge clk);
                #2;
                check("stall_in_ready", {31'd0, in_ready}, 32'd0);
                check("stall_hold", {9'd0, out_valid, sum, cout, ovf, skip}, {9'd0, snap});
            end
            ready_mode = 0;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: an output transfer is decided by the levels seen just before the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    note_fail("unexpected_output");
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("result", {10'd0, sum, cout, ovf, skip}, {10'd0, mon_exp});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int stray;
        rst_n = 1'b0;
        #3;
        check("reset_outputs", {9'd0, out_valid, sum, cout, ovf, skip}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed corner cases with hand-derived results
        send_lat(16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1, 4'b0110});
        send_exp(16'h0005, 16'h0007, 1'b0, 1'b1, {16'hFFFE, 1'b0, 1'b0, 4'b1110});
        send_exp(16'hFFFF, 16'h0000, 1'b1, 1'b0, {16'h0000, 1'b1, 1'b0, 4'b1111});
        send_exp(16'h8000, 16'h8000, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b1, 4'b0000});
        send_exp(16'h0005, 16'h0007, 1'b1, 1'b1, {16'hFFFE, 1'b0, 1'b0, 4'b1110});
        send_exp(16'h1234, 16'h1234, 1'b0, 1'b1, {16'h0000, 1'b1, 1'b0, 4'b1111});
        wait_drain("directed_drain");

        // Backpressure on a back-to-back stream
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
            end
            stall_check();
        join
        wait_drain("backpressure_drain");

        // Asynchronous reset with two results in flight
        send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {9'd0, out_valid, sum, cout, ovf, skip}, 32'd0);
        check("async_reset_in_ready", {31'd0, in_ready}, 32'd1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        stray = 0;
        repeat (4) begin
            @(negedge clk);
            #2;
            if (out_valid) stray++;
        end
        check("no_stale_result", stray, 32'd0);
        send_lat(16'h4321, 16'h1111, 1'b1, 1'b0, model(16'h4321, 16'h1111, 1'b1, 1'b0));
        wait_drain("post_reset_drain");

        // Random traffic with random downstream readiness
        ready_mode = 2;
        repeat (150) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        ready_mode = 0;
        wait_drain("final_drain");

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
